// File: rtl/core_pkg.sv
// Shared core definitions: divider FSM state encoding and the latency the hazard unit stalls for.
package core_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIN  = 2'd2
  } div_state_t;

  localparam int DIV_N   = 32;
  localparam int DIV_LAT = DIV_N + 1;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate, used to restore signs on the divider magnitude results.
module div_sign_fix #(
  parameter int N = 32
) (
  input  logic [N-1:0] mag,
  input  logic         negate,
  output logic [N-1:0] result
);

  localparam logic [N-1:0] ONE = N'(1);

  // Negate the magnitude when the signed result must be negative.
  always_comb begin
    if (negate) begin
      result = ~mag + ONE;
    end else begin
      result = mag;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle, start/busy/done handshake.
module seq_divider
  import core_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         is_signed,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int            CW   = $clog2(N);
  localparam logic [N-1:0]  ONE  = N'(1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  div_state_t    state_r;
  logic [CW-1:0] cnt_r;
  logic [N:0]    acc_r;
  logic [N-1:0]  quo_r;
  logic [N-1:0]  dvs_r;
  logic          q_neg_r;
  logic          r_neg_r;

  logic          dvd_neg_s;
  logic          dvs_neg_s;
  logic [N-1:0]  dvd_mag_s;
  logic [N-1:0]  dvs_mag_s;
  logic [N:0]    shift_s;
  logic [N:0]    diff_s;
  logic [N:0]    acc_nxt_s;
  logic [N-1:0]  quo_nxt_s;
  logic [N-1:0]  q_fix_s;
  logic [N-1:0]  r_fix_s;

  // Operand sign detection and magnitudes, sampled on an accepted start.
  always_comb begin
    dvd_neg_s = is_signed & dividend[N-1];
    dvs_neg_s = is_signed & divisor[N-1];
    if (dvd_neg_s) begin
      dvd_mag_s = ~dividend + ONE;
    end else begin
      dvd_mag_s = dividend;
    end
    if (dvs_neg_s) begin
      dvs_mag_s = ~divisor + ONE;
    end else begin
      dvs_mag_s = divisor;
    end
  end

  // One restoring step: shift in the next dividend bit, keep the difference if non-negative.
  always_comb begin
    shift_s = {acc_r[N-1:0], quo_r[N-1]};
    diff_s  = shift_s - {1'b0, dvs_r};
    if (!diff_s[N]) begin
      acc_nxt_s = diff_s;
      quo_nxt_s = {quo_r[N-2:0], 1'b1};
    end else begin
      acc_nxt_s = shift_s;
      quo_nxt_s = {quo_r[N-2:0], 1'b0};
    end
  end

  div_sign_fix #(.N(N)) u_fix_quo (
    .mag    (quo_nxt_s),
    .negate (q_neg_r),
    .result (q_fix_s)
  );

  div_sign_fix #(.N(N)) u_fix_rem (
    .mag    (acc_nxt_s[N-1:0]),
    .negate (r_neg_r),
    .result (r_fix_s)
  );

  // Control FSM, iteration datapath and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= DIV_IDLE;
      cnt_r       <= '0;
      acc_r       <= '0;
      quo_r       <= '0;
      dvs_r       <= '0;
      q_neg_r     <= 1'b0;
      r_neg_r     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (flush) begin
      state_r <= DIV_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_r)
        DIV_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (divisor == '0) begin
              // RISC-V divide-by-zero result, skipping the iteration entirely.
              state_r     <= DIV_FIN;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state_r     <= DIV_CALC;
              div_by_zero <= 1'b0;
              cnt_r       <= LAST;
              acc_r       <= '0;
              quo_r       <= dvd_mag_s;
              dvs_r       <= dvs_mag_s;
              q_neg_r     <= dvd_neg_s ^ dvs_neg_s;
              r_neg_r     <= dvd_neg_s;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        DIV_CALC: begin
          acc_r <= acc_nxt_s;
          quo_r <= quo_nxt_s;
          if (cnt_r == '0) begin
            state_r   <= DIV_FIN;
            done      <= 1'b1;
            quotient  <= q_fix_s;
            remainder <= r_fix_s;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        DIV_FIN: begin
          state_r <= DIV_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          state_r <= DIV_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (N=32) with hand-computed expectations.
module tb_seq_divider;
  import core_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_pass  = 0;
  int n_total = 0;

  seq_divider #(.N(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance to one time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_res(input string tag, input logic [31:0] q, input logic [31:0] r, input logic z);
    chk({tag, ".quotient"}, 64'(quotient), 64'(q));
    chk({tag, ".remainder"}, 64'(remainder), 64'(r));
    chk({tag, ".div_by_zero"}, 64'(div_by_zero), 64'(z));
  endtask

  // Issue a start in the current cycle, follow busy/done for lat cycles; optional ignored start at cycle glitch.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input int lat, input int glitch);
    dividend  = a;
    divisor   = b;
    is_signed = sgn;
    start     = 1'b1;
    for (int i = 1; i <= lat; i++) begin
      tick();
      start = 1'b0;
      if (i == glitch) begin
        start    = 1'b1;
        dividend = 32'd5;
        divisor  = 32'd0;
      end
      chk($sformatf("%s.busy@%0d", tag, i), 64'(busy), 64'(1));
      chk($sformatf("%s.done@%0d", tag, i), 64'(done), (i == lat) ? 64'(1) : 64'(0));
    end
  endtask

  task automatic chk_idle(input string tag);
    tick();
    chk({tag, ".busy_after"}, 64'(busy), 64'(0));
    chk({tag, ".done_after"}, 64'(done), 64'(0));
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    flush     = 1'b0;
    is_signed = 1'b0;
    dividend  = 32'd0;
    divisor   = 32'd0;
    tick();
    tick();
    chk("reset.busy", 64'(busy), 64'(0));
    chk("reset.done", 64'(done), 64'(0));
    chk_res("reset", 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1;
    tick();

    // 1: unsigned 100/7
    run_op("t1", 32'd100, 32'd7, 1'b0, DIV_LAT, 0);
    chk_res("t1", 32'd14, 32'd2, 1'b0);
    chk_idle("t1");

    // 2: signed -100/7
    run_op("t2", 32'hFFFF_FF9C, 32'd7, 1'b1, DIV_LAT, 0);
    chk_res("t2", 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    chk_idle("t2");

    // 3: divide by zero fast path
    run_op("t3", 32'h0000_1234, 32'd0, 1'b0, 1, 0);
    chk_res("t3", 32'hFFFF_FFFF, 32'h0000_1234, 1'b1);
    chk_idle("t3");

    // 4: signed overflow
    run_op("t4", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, DIV_LAT, 0);
    chk_res("t4", 32'h8000_0000, 32'h0, 1'b0);
    chk_idle("t4");

    // 5: flush at T+10 of 100/7, then a fresh start at T+12
    dividend  = 32'd100;
    divisor   = 32'd7;
    is_signed = 1'b0;
    start     = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      start = 1'b0;
      chk($sformatf("t5.done@%0d", i), 64'(done), 64'(0));
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5.busy_flushed", 64'(busy), 64'(0));
    chk("t5.done_flushed", 64'(done), 64'(0));
    chk_res("t5.held", 32'h8000_0000, 32'h0, 1'b0);
    tick();
    chk("t5.done_quiet", 64'(done), 64'(0));
    run_op("t5b", 32'd100, 32'd7, 1'b0, DIV_LAT, 0);
    chk_res("t5b", 32'd14, 32'd2, 1'b0);
    chk_idle("t5b");

    // 6a: start pulsed mid-CALC is ignored
    run_op("t6a", 32'd1000, 32'd10, 1'b0, DIV_LAT, 5);
    chk_res("t6a", 32'd100, 32'd0, 1'b0);
    chk_idle("t6a");

    // 6b: start and flush together in IDLE; start is dropped
    dividend = 32'd9;
    divisor  = 32'd0;
    start    = 1'b1;
    flush    = 1'b1;
    tick();
    start = 1'b0;
    flush = 1'b0;
    chk("t6b.busy", 64'(busy), 64'(0));
    chk("t6b.done", 64'(done), 64'(0));
    tick();
    chk("t6b.done_next", 64'(done), 64'(0));
    chk_res("t6b", 32'd100, 32'd0, 1'b0);

    // 6c: asynchronous reset mid-CALC
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("t6c.busy_pre", 64'(busy), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6c.busy", 64'(busy), 64'(0));
    chk("t6c.done", 64'(done), 64'(0));
    chk_res("t6c", 32'h0, 32'h0, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t6c.idle@%0d", i), 64'({busy, done}), 64'(0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
